// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  localparam logic [31:0] FETCH_RESET_PC = 32'h0040_0000;
  localparam logic [31:0] PC_STEP        = 32'd4;
  localparam logic [6:0]  OPC_JAL        = 7'b1101111;

  // Sign-extended J-type immediate (byte offset, bit 0 always zero).
  function automatic logic [31:0] j_imm(input logic [31:0] instr);
    return {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
  endfunction

endpackage

// File: rtl/fetch_if.sv
// Instruction memory request/response channel between fetch (master) and memory (slave).
interface fetch_if;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;

  modport master (
    output imem_req_valid, imem_req_addr,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data
  );

  modport slave (
    input  imem_req_valid, imem_req_addr,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data
  );
endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry instruction+PC holding buffer used while decode is stalled.
module fetch_skid_buf (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        load,
  input  logic        pop,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  output logic        valid,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc
);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
    end else if (pop) begin
      valid <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      out_instr <= '0;
      out_pc    <= '0;
    end else if (load) begin
      out_instr <= in_instr;
      out_pc    <= in_pc;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC, imem request FSM, IF/ID output regs with skid buffer.
// Optional JAL target prediction is enabled by defining FETCH_JAL_PREDICT_EN.
//
// state    | meaning
// IDLE     | just out of reset, no request yet
// REQ      | presenting a request (held off while the skid buffer is full)
// WAIT     | one request outstanding, response is live
// DRAIN    | one request outstanding, response is stale and will be dropped
module fetch_stage
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = FETCH_RESET_PC
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  fetch_if.master     imem,
  output logic [31:0] instruction_w,
  output logic [31:0] sig_pc_w,
  output logic        fetch_valid,
  output logic        flush
);

  fetch_state_e state, state_nxt;
  logic [31:0] pc, req_pc;
  logic        req_valid, req_fire;
  logic        rsp_live, deliver_out, skid_load, skid_pop;
  logic        skid_valid;
  logic [31:0] skid_instr, skid_pc;
  logic        jal_taken;
  logic [31:0] jal_target;

  assign imem.imem_req_valid = req_valid;
  assign imem.imem_req_addr  = pc;
  assign req_fire    = req_valid && imem.imem_req_ready;
  assign rsp_live    = (state == ST_WAIT) && imem.imem_rsp_valid && !redirect_valid;
  assign deliver_out = rsp_live && (!fetch_valid || !stall);
  assign skid_load   = rsp_live && fetch_valid && stall;
  assign skid_pop    = skid_valid && !stall && !redirect_valid;

`ifdef FETCH_JAL_PREDICT_EN
  assign jal_taken  = rsp_live && (imem.imem_rsp_data[6:0] == OPC_JAL);
  assign jal_target = req_pc + j_imm(imem.imem_rsp_data);
`else
  assign jal_taken  = 1'b0;
  assign jal_target = '0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    req_valid = 1'b0;
    unique case (state)
      ST_IDLE: state_nxt = ST_REQ;
      ST_REQ: begin
        req_valid = !skid_valid;
        if (redirect_valid)
          state_nxt = (req_valid && imem.imem_req_ready) ? ST_DRAIN : ST_REQ;
        else if (req_valid && imem.imem_req_ready)
          state_nxt = ST_WAIT;
      end
      // A response in the redirect cycle retires the request, so no drain is needed.
      ST_WAIT: begin
        if (imem.imem_rsp_valid)  state_nxt = ST_REQ;
        else if (redirect_valid)  state_nxt = ST_DRAIN;
      end
      ST_DRAIN: if (imem.imem_rsp_valid) state_nxt = ST_REQ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc     <= RESET_PC;
      req_pc <= RESET_PC;
    end else begin
      if (req_fire) req_pc <= pc;
      if (redirect_valid)  pc <= redirect_pc & ~32'd3;
      else if (jal_taken)  pc <= jal_target;
      else if (req_fire)   pc <= pc + PC_STEP;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instruction_w <= '0;
      sig_pc_w      <= '0;
      fetch_valid   <= 1'b0;
      flush         <= 1'b1;
    end else begin
      flush <= !redirect_valid;
      if (redirect_valid) begin
        fetch_valid <= 1'b0;
      end else if (deliver_out) begin
        instruction_w <= imem.imem_rsp_data;
        sig_pc_w      <= req_pc;
        fetch_valid   <= 1'b1;
      end else if (!stall) begin
        if (skid_valid) begin
          instruction_w <= skid_instr;
          sig_pc_w      <= skid_pc;
        end
        fetch_valid <= skid_valid;
      end
    end
  end

  fetch_skid_buf u_skid (
    .clk       (clk),
    .reset     (reset),
    .clear     (redirect_valid),
    .load      (skid_load),
    .pop       (skid_pop),
    .in_instr  (imem.imem_rsp_data),
    .in_pc     (req_pc),
    .valid     (skid_valid),
    .out_instr (skid_instr),
    .out_pc    (skid_pc)
  );

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: per-cycle vector table plus redirect/reset/JAL sequences.
module tb_fetch_stage;

  localparam logic [31:0] W0  = 32'h0010_0013;
  localparam logic [31:0] W1  = 32'h0020_0013;
  localparam logic [31:0] W2  = 32'h0030_0013;
  localparam logic [31:0] W3  = 32'h0040_0013;
  localparam logic [31:0] W4  = 32'h0050_0013;
  localparam logic [31:0] W5  = 32'h0060_0013;
  localparam logic [31:0] W6  = 32'h0070_0013;
  localparam logic [31:0] W7  = 32'h0080_0013;
  localparam logic [31:0] W8  = 32'h0090_0013;
  localparam logic [31:0] JAL = 32'h0200_006F;  // jal x0, +0x20
`ifdef FETCH_JAL_PREDICT_EN
  localparam logic [31:0] JAL_NEXT = 32'h0040_0030;
`else
  localparam logic [31:0] JAL_NEXT = 32'h0040_0014;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic [31:0] instruction_w, sig_pc_w;
  logic        fetch_valid, flush;

  fetch_if imem_bus ();

  fetch_stage dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem           (imem_bus),
    .instruction_w  (instruction_w),
    .sig_pc_w       (sig_pc_w),
    .fetch_valid    (fetch_valid),
    .flush          (flush)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall, rdy, rsv;
    logic [31:0] rsd;
    logic        e_rv;
    logic [31:0] e_addr;
    logic        e_fv;
    logic [31:0] e_ins, e_pc;
  } vec_t;

  vec_t tbl [15];
  int   n_chk = 0;
  int   n_fail = 0;

  function automatic vec_t mk(input logic st, rdy, rsv, input logic [31:0] rsd,
                              input logic erv, input logic [31:0] eaddr,
                              input logic efv, input logic [31:0] eins, epc);
    vec_t v;
    v.stall = st; v.rdy = rdy; v.rsv = rsv; v.rsd = rsd;
    v.e_rv = erv; v.e_addr = eaddr; v.e_fv = efv; v.e_ins = eins; v.e_pc = epc;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs at the negedge, then advance to the next negedge.
  task automatic step(input logic st, rv, input logic [31:0] rpc,
                      input logic rdy, rsv, input logic [31:0] rsd);
    stall = st;
    redirect_valid = rv;
    redirect_pc = rpc;
    imem_bus.imem_req_ready = rdy;
    imem_bus.imem_rsp_valid = rsv;
    imem_bus.imem_rsp_data = rsd;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    tbl[0]  = mk(0, 1, 0, '0, 0, 32'h0040_0000, 0, '0, '0);
    tbl[1]  = mk(0, 1, 0, '0, 1, 32'h0040_0000, 0, '0, '0);
    tbl[2]  = mk(0, 1, 1, W0, 0, 32'h0040_0004, 0, '0, '0);
    tbl[3]  = mk(0, 1, 0, '0, 1, 32'h0040_0004, 1, W0, 32'h0040_0000);
    tbl[4]  = mk(0, 1, 1, W1, 0, 32'h0040_0008, 0, W0, 32'h0040_0000);
    tbl[5]  = mk(0, 1, 0, '0, 1, 32'h0040_0008, 1, W1, 32'h0040_0004);
    tbl[6]  = mk(0, 1, 1, W2, 0, 32'h0040_000C, 0, W1, 32'h0040_0004);
    tbl[7]  = mk(1, 1, 0, '0, 1, 32'h0040_000C, 1, W2, 32'h0040_0008);
    tbl[8]  = mk(1, 1, 1, W3, 0, 32'h0040_0010, 1, W2, 32'h0040_0008);
    tbl[9]  = mk(1, 1, 0, '0, 0, 32'h0040_0010, 1, W2, 32'h0040_0008);
    tbl[10] = mk(1, 1, 0, '0, 0, 32'h0040_0010, 1, W2, 32'h0040_0008);
    tbl[11] = mk(1, 1, 0, '0, 0, 32'h0040_0010, 1, W2, 32'h0040_0008);
    tbl[12] = mk(0, 0, 0, '0, 0, 32'h0040_0010, 1, W2, 32'h0040_0008);
    tbl[13] = mk(0, 0, 0, '0, 1, 32'h0040_0010, 1, W3, 32'h0040_000C);
    tbl[14] = mk(0, 0, 0, '0, 1, 32'h0040_0010, 0, W3, 32'h0040_000C);

    imem_bus.imem_req_ready = 1'b0;
    imem_bus.imem_rsp_valid = 1'b0;
    imem_bus.imem_rsp_data  = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst_flush", {31'b0, flush}, 32'd1);
    chk("rst_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd0);
    chk("rst_req_addr", imem_bus.imem_req_addr, 32'h0040_0000);
    chk("rst_instruction", instruction_w, 32'd0);
    chk("rst_sig_pc", sig_pc_w, 32'd0);
    reset = 1'b0;

    // Sequential fetch, then a five-cycle stall that fills the skid buffer.
    for (int i = 0; i < 15; i++) begin
      stall = tbl[i].stall;
      imem_bus.imem_req_ready = tbl[i].rdy;
      imem_bus.imem_rsp_valid = tbl[i].rsv;
      imem_bus.imem_rsp_data  = tbl[i].rsd;
      #1;
      chk($sformatf("v%0d_req_valid", i), {31'b0, imem_bus.imem_req_valid}, {31'b0, tbl[i].e_rv});
      chk($sformatf("v%0d_req_addr", i), imem_bus.imem_req_addr, tbl[i].e_addr);
      chk($sformatf("v%0d_fetch_valid", i), {31'b0, fetch_valid}, {31'b0, tbl[i].e_fv});
      chk($sformatf("v%0d_instruction", i), instruction_w, tbl[i].e_ins);
      chk($sformatf("v%0d_sig_pc", i), sig_pc_w, tbl[i].e_pc);
      chk($sformatf("v%0d_flush", i), {31'b0, flush}, 32'd1);
      @(posedge clk);
      @(negedge clk);
    end

    // Redirect while waiting: stale response dropped, new request at aligned target.
    step(0, 0, '0, 1, 0, '0);
    chk("rdw_wait_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd0);
    chk("rdw_wait_addr", imem_bus.imem_req_addr, 32'h0040_0014);
    step(0, 1, 32'h0040_0103, 0, 0, '0);
    chk("rdw_flush_low", {31'b0, flush}, 32'd0);
    chk("rdw_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rdw_drain_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd0);
    chk("rdw_target_addr", imem_bus.imem_req_addr, 32'h0040_0100);
    step(0, 0, '0, 1, 1, W4);
    chk("rdw_flush_back", {31'b0, flush}, 32'd1);
    chk("rdw_stale_dropped", {31'b0, fetch_valid}, 32'd0);
    chk("rdw_new_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd1);
    chk("rdw_new_req_addr", imem_bus.imem_req_addr, 32'h0040_0100);
    step(0, 0, '0, 1, 0, '0);
    step(0, 0, '0, 0, 1, W5);
    chk("rdw_deliver_valid", {31'b0, fetch_valid}, 32'd1);
    chk("rdw_deliver_ins", instruction_w, W5);
    chk("rdw_deliver_pc", sig_pc_w, 32'h0040_0100);

    // Redirect coinciding with the response.
    step(0, 0, '0, 1, 0, '0);
    step(0, 1, 32'h0040_0200, 0, 1, W6);
    chk("rdr_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rdr_flush_low", {31'b0, flush}, 32'd0);
    chk("rdr_ins_held", instruction_w, W5);
    chk("rdr_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd1);
    chk("rdr_req_addr", imem_bus.imem_req_addr, 32'h0040_0200);

    // Reset while a request is outstanding; late response ignored.
    step(0, 0, '0, 1, 0, '0);
    reset = 1'b1;
    step(0, 0, '0, 0, 0, '0);
    step(0, 0, '0, 0, 0, '0);
    reset = 1'b0;
    step(0, 0, '0, 0, 1, W7);
    chk("rst2_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    chk("rst2_ins", instruction_w, 32'd0);
    chk("rst2_flush", {31'b0, flush}, 32'd1);
    chk("rst2_req_valid", {31'b0, imem_bus.imem_req_valid}, 32'd1);
    chk("rst2_req_addr", imem_bus.imem_req_addr, 32'h0040_0000);

    // JAL at 0x00400010.
    step(0, 1, 32'h0040_0010, 0, 0, '0);
    chk("jal_redir_flush", {31'b0, flush}, 32'd0);
    chk("jal_redir_addr", imem_bus.imem_req_addr, 32'h0040_0010);
    step(0, 0, '0, 1, 0, '0);
    step(0, 0, '0, 0, 1, JAL);
    chk("jal_ins", instruction_w, JAL);
    chk("jal_pc", sig_pc_w, 32'h0040_0010);
    chk("jal_flush", {31'b0, flush}, 32'd1);
    chk("jal_next_req_addr", imem_bus.imem_req_addr, JAL_NEXT);
    step(0, 0, '0, 1, 0, '0);
    step(0, 0, '0, 0, 1, W8);
    chk("jal_next_ins", instruction_w, W8);
    chk("jal_next_pc", sig_pc_w, JAL_NEXT);
    chk("jal_next_valid", {31'b0, fetch_valid}, 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction fetch stage: owns the PC, issues word requests to instruction memory over a valid/ready request channel, and presents fetched instructions with their PC to the IF/ID pipeline register. It is the producing end of the IF/ID interface and drives `instruction_w`, `sig_pc_w` and the register's active-low `flush`. It absorbs decode stalls with a one-entry skid buffer and EX-stage redirects (branch/jump) by discarding stale responses.

## Interface
- `RESET_PC`, 32'h0040_0000, PC fetched first after reset.
- `clk` in 1, sole clock; all logic on posedge.
- `reset` in 1, synchronous, active-high.
- `stall` in 1, decode hazard; 1 = IF/ID not consuming this cycle.
- `redirect_valid` in 1, EX redirect request.
- `redirect_pc` in 32, redirect target; bits [1:0] forced to 0.
- `imem_req_valid` out 1, request valid.
- `imem_req_ready` in 1, memory accepts request.
- `imem_req_addr` out 32, word address (byte PC).
- `imem_rsp_valid` in 1, response valid (no backpressure).
- `imem_rsp_data` in 32, instruction word.
- `instruction_w` out 32, instruction to IF/ID.
- `sig_pc_w` out 32, PC of `instruction_w`.
- `fetch_valid` out 1, `instruction_w`/`sig_pc_w` hold a live instruction.
- `flush` out 1, active-low flush to IF/ID.

## Operation
- FSM: IDLE, REQ, WAIT, DRAIN.
  - IDLE: entered on reset; unconditionally moves to REQ next cycle.
  - REQ: `imem_req_valid`=1 when skid buffer empty; on valid&ready go WAIT, `pc <= pc + 4` (mod 2^32).
  - WAIT: on `imem_rsp_valid` go REQ, deliver response.
  - DRAIN: outstanding response is stale; on `imem_rsp_valid` drop it, go REQ.
- One outstanding request maximum.
- Delivery of a live response: if output empty or `stall`=0, load output regs; else load skid buffer. Skid buffer feeds output when `stall`=0.
- Output consumed each cycle `stall`=0; `fetch_valid` clears if nothing replaces it.
- Redirect (`redirect_valid`=1):
  - `pc <= redirect_pc & ~3`.
  - Clear `fetch_valid` and skid.
  - WAIT → DRAIN.
  - REQ with request accepted same cycle → DRAIN.
  - Otherwise → REQ.
  - A response arriving in the redirect cycle is dropped.
- Priority: reset > redirect > response delivery > stall.
- Reset values: `instruction_w`=0, `sig_pc_w`=0, `fetch_valid`=0, `flush`=1, `imem_req_valid`=0, `imem_req_addr`=`RESET_PC`, skid empty.

## Timing
- `imem_req_addr` = registered PC; `imem_req_valid` combinational from state and skid only (no input paths).
- Response → `instruction_w` visible: 1 cycle (registered on the edge where `imem_rsp_valid`=1).
- Best-case throughput with 1-cycle memory: one instruction per 2 cycles.
- `flush`: registered; 0 for exactly the one cycle following a sampled redirect; glitch-free.
- Redirect → first new request: cycle after the redirect edge (REQ path), or the cycle after the stale response (DRAIN path).
- `stall` held indefinitely: outputs and skid frozen; no new requests once skid full.

## Configuration
- `FETCH_JAL_PREDICT_EN`:
  - Defined: on delivery of a live response with opcode 7'b1101111 (JAL), next PC = `sig_pc` + sign-extended J-immediate instead of pc+4. If the request for pc+4 is already outstanding, it is drained first. No flush is generated.
  - Undefined: strictly sequential pc+4 fetch; only `redirect_valid` alters the PC.

## Structure
- Shared package `fetch_pkg`:
  - FSM state encoding.
  - `OPC_JAL`.
  - `PC_STEP`=4.
  - J-immediate extraction function.
- Sub-module `fetch_skid_buf` (one-entry instruction+PC buffer with valid).
- All else inline.

## Test plan
- Reset, memory always ready, 1-cycle response: requests at 0x00400000, 0x00400004, 0x00400008; `instruction_w` matches memory, `fetch_valid` pulses; `flush`=1 throughout.
- `stall`=1 for 5 cycles while a response arrives: output held at the stalled instruction, skid captures next; on release, the two instructions appear on consecutive cycles in order; no request issued while skid full.
- `redirect_valid` with `redirect_pc`=0x00400103 during WAIT: next request at 0x00400100; stale response dropped; `fetch_valid`=0 and `flush`=0 for one cycle.
- Redirect and `imem_rsp_valid` in the same cycle: response dropped; next request to the target.
- `reset` mid-WAIT, then a late response: ignored; first request at `RESET_PC`.
- With `FETCH_JAL_PREDICT_EN`, fetch JAL +0x20 at 0x00400010: next delivered PC is 0x00400030. Without the macro, next delivered PC is 0x00400014.
